// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: one instruction in flight, drives operand
// selects for its whole lifetime and strobes memory, writeback and PC update.
module multicycle_ctrl #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic [1:0]       operand_ASel,
    output logic [1:0]       extend_Sel,
    output logic             operand_BSel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_wr_en,
    output logic             wb_sel,
    output logic             pc_en,
    output logic [1:0]       next_pc_sel,
    output logic             illegal_instr,
    output logic [RET_W-1:0] retired
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] asel;
        logic [1:0] ext;
        logic       bsel;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] op);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (op)
            OP_R, OP_BRANCH:            ;
            OP_IALU, OP_LOAD:           d.bsel = 1'b1;
            OP_STORE:  begin d.bsel = 1'b1; d.ext = 2'b10; end
            OP_JAL, OP_JALR:            d.asel = 2'b01;
            OP_LUI:    begin d.asel = 2'b11; d.bsel = 1'b1; d.ext = 2'b01; end
            OP_AUIPC:  begin d.asel = 2'b10; d.bsel = 1'b1; d.ext = 2'b01; end
            default:                    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       op_q;
    dec_t             sel_q;
    logic [RET_W-1:0] retired_q;
    logic             retire;
    logic             accept;
    logic             unused_instr_hi;

    assign unused_instr_hi = ^instr[31:7];
    assign accept = (state_q == S_FETCH) && instr_valid && !halt;

    // Selects are decoded straight off the fetched word at accept so they are
    // already stable during DECODE and hold until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            sel_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= instr[6:0];
                sel_q <= decode(instr[6:0]);
            end
            if (retire) retired_q <= retired_q + RET_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_ready   = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        reg_wr_en     = 1'b0;
        wb_sel        = 1'b0;
        pc_en         = 1'b0;
        next_pc_sel   = 2'b00;
        illegal_instr = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_ready = !halt;
                if (accept) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (decode(op_q).legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_instr = 1'b1;
                    pc_en         = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    pc_en       = 1'b1;
                    next_pc_sel = {1'b0, branch_taken};
                    retire      = 1'b1;
                    state_d     = S_FETCH;
                end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (mem_ack) begin
                    if (op_q == OP_STORE) begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wr_en   = 1'b1;
                wb_sel      = (op_q == OP_LOAD);
                pc_en       = 1'b1;
                retire      = 1'b1;
                next_pc_sel = (op_q == OP_JAL)  ? 2'b10 :
                              (op_q == OP_JALR) ? 2'b11 : 2'b00;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign operand_ASel = sel_q.asel;
    assign extend_Sel   = sel_q.ext;
    assign operand_BSel = sel_q.bsel;
    assign retired      = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction phase model drives
// expectations that a negedge compare process checks every cycle.
module tb_multicycle_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, halt = 1'b0, instr_valid = 1'b0;
    logic        branch_taken = 1'b0, mem_ack = 1'b0;
    logic [31:0] instr = '0;

    logic        instr_ready, operand_BSel, mem_req, mem_we, reg_wr_en, wb_sel, pc_en, illegal_instr;
    logic [1:0]  operand_ASel, extend_Sel, next_pc_sel;
    logic [31:0] retired;

    logic        r2_ready, r2_bsel, r2_req, r2_we, r2_wr, r2_wb, r2_pc, r2_ill;
    logic [1:0]  r2_asel, r2_ext, r2_npc, r2_ret;

    multicycle_ctrl #(.RET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .branch_taken(branch_taken),
        .mem_ack(mem_ack), .operand_ASel(operand_ASel), .extend_Sel(extend_Sel),
        .operand_BSel(operand_BSel), .mem_req(mem_req), .mem_we(mem_we),
        .reg_wr_en(reg_wr_en), .wb_sel(wb_sel), .pc_en(pc_en),
        .next_pc_sel(next_pc_sel), .illegal_instr(illegal_instr), .retired(retired));

    multicycle_ctrl #(.RET_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .halt(halt), .instr_valid(instr_valid),
        .instr_ready(r2_ready), .instr(instr), .branch_taken(branch_taken),
        .mem_ack(mem_ack), .operand_ASel(r2_asel), .extend_Sel(r2_ext),
        .operand_BSel(r2_bsel), .mem_req(r2_req), .mem_we(r2_we),
        .reg_wr_en(r2_wr), .wb_sel(r2_wb), .pc_en(r2_pc),
        .next_pc_sel(r2_npc), .illegal_instr(r2_ill), .retired(r2_ret));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic [1:0] asel, ext;
        logic       bsel, mem_req, mem_we, reg_wr, wb_sel, pc_en;
        logic [1:0] npc;
        logic       illegal;
    } exp_t;

    exp_t exp_o = '0;
    logic chk_en = 1'b0, chk_sel = 1'b0;
    int   exp_ret = 0;
    int   tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_ready", instr_ready, exp_o.ready);
            check("mem_req", mem_req, exp_o.mem_req);
            check("reg_wr_en", reg_wr_en, exp_o.reg_wr);
            check("pc_en", pc_en, exp_o.pc_en);
            check("illegal_instr", illegal_instr, exp_o.illegal);
            if (exp_o.mem_req) check("mem_we", mem_we, exp_o.mem_we);
            if (exp_o.reg_wr)  check("wb_sel", wb_sel, exp_o.wb_sel);
            if (exp_o.pc_en)   check("next_pc_sel", next_pc_sel, exp_o.npc);
            if (chk_sel) begin
                check("operand_ASel", operand_ASel, exp_o.asel);
                check("extend_Sel", extend_Sel, exp_o.ext);
                check("operand_BSel", operand_BSel, exp_o.bsel);
            end
            check("retired", retired, exp_ret);
            check("retired_w2", r2_ret, exp_ret % 4);
        end
    end

    // Operand-select table straight from the opcode list; legal=0 for unknowns.
    function automatic void sels(input logic [6:0] op, output logic legal,
                                 output logic [1:0] a, output logic [1:0] e, output logic b);
        legal = 1'b1; a = 2'b00; e = 2'b00; b = 1'b0;
        case (op)
            7'b0110011, 7'b1100011: ;
            7'b0010011, 7'b0000011: b = 1'b1;
            7'b0100011: begin b = 1'b1; e = 2'b10; end
            7'b1101111, 7'b1100111: a = 2'b01;
            7'b0110111: begin a = 2'b11; b = 1'b1; e = 2'b01; end
            7'b0010111: begin a = 2'b10; b = 1'b1; e = 2'b01; end
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Entered #1 after a posedge with the DUT in FETCH; returns cycles from
    // the accept cycle up to (not including) the next FETCH cycle.
    task automatic run(input logic [6:0] op, input logic bt, input int ack_n,
                       input logic junk_ack, output int lat);
        logic [31:0] w;
        logic legal, bsel, ld, st, br;
        logic [1:0] asel, ext;
        sels(op, legal, asel, ext, bsel);
        ld = (op == 7'b0000011); st = (op == 7'b0100011); br = (op == 7'b1100011);
        w = $urandom(); w[6:0] = op;
        instr = w; instr_valid = 1'b1;
        exp_o = '0; exp_o.ready = 1'b1; chk_sel = 1'b0;
        step(); lat = 1;
        instr_valid = 1'b0;
        exp_o = '0; exp_o.asel = asel; exp_o.ext = ext; exp_o.bsel = bsel; chk_sel = 1'b1;
        mem_ack = junk_ack;
        if (!legal) begin exp_o.illegal = 1'b1; exp_o.pc_en = 1'b1; end
        step(); lat++;
        if (legal) begin
            branch_taken = bt;
            if (br) begin exp_o.pc_en = 1'b1; exp_o.npc = {1'b0, bt}; end
            step(); lat++;
            branch_taken = 1'b0;
            if (br) exp_ret++;
            if (ld || st) begin
                for (int i = 1; i <= ack_n; i++) begin
                    exp_o.mem_req = 1'b1; exp_o.mem_we = st;
                    mem_ack = (i == ack_n);
                    if (i == ack_n && st) begin exp_o.pc_en = 1'b1; exp_o.npc = 2'b00; end
                    step(); lat++;
                end
                exp_o.mem_req = 1'b0; exp_o.pc_en = 1'b0;
                if (st) exp_ret++;
            end
            mem_ack = 1'b0;
            if (!br && !st) begin
                exp_o.reg_wr = 1'b1; exp_o.wb_sel = ld; exp_o.pc_en = 1'b1;
                exp_o.npc = (op == 7'b1101111) ? 2'b10 : (op == 7'b1100111) ? 2'b11 : 2'b00;
                step(); lat++;
                exp_ret++;
            end
        end
        mem_ack = 1'b0;
        exp_o = '0; exp_o.ready = 1'b1; chk_sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // Reset held with a valid instruction waiting: all outputs 0, ready=1.
        instr = 32'h0000_0013; instr_valid = 1'b1;
        exp_o = '0; exp_o.ready = 1'b1; chk_sel = 1'b1; chk_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        run(7'b0010011, 1'b0, 0, 1'b0, lat); check("lat_addi", lat, 4);
        check("retired_after_addi", retired, 1);
        run(7'b0000011, 1'b0, 3, 1'b1, lat); check("lat_lw_wait3", lat, 7);
        run(7'b0100011, 1'b0, 1, 1'b0, lat); check("lat_sw_imm", lat, 4);
        run(7'b1100011, 1'b1, 0, 1'b0, lat); check("lat_beq_taken", lat, 3);
        run(7'b1100011, 1'b0, 0, 1'b0, lat); check("lat_beq_not", lat, 3);
        check("retired_w2_after5", r2_ret, 1);
        run(7'b1101111, 1'b1, 0, 1'b0, lat); check("lat_jal", lat, 4);
        run(7'b1100111, 1'b0, 0, 1'b1, lat);
        run(7'b0110111, 1'b0, 0, 1'b0, lat);
        run(7'b0010111, 1'b0, 0, 1'b0, lat);
        run(7'b0110011, 1'b1, 0, 1'b0, lat); check("lat_r", lat, 4);
        run(7'b1111111, 1'b0, 0, 1'b0, lat); check("lat_illegal", lat, 2);
        check("retired_after_illegal", retired, 10);

        // halt in FETCH blocks acceptance even with a valid instruction.
        halt = 1'b1; instr = 32'h0000_0033; instr_valid = 1'b1; exp_o.ready = 1'b0;
        repeat (3) step();
        halt = 1'b0; instr_valid = 1'b0; exp_o.ready = 1'b1;
        step();
        run(7'b0010011, 1'b0, 0, 1'b0, lat); check("lat_after_halt", lat, 4);

        // Reset asserted while a load waits in MEM.
        chk_en = 1'b0;
        instr = 32'h0000_0003; instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        step(); step(); step();
        check("mem_req_before_rst", mem_req, 1);
        rst_n = 1'b0; #1;
        check("mem_req_in_rst", mem_req, 0);
        check("ready_in_rst", instr_ready, 1);
        check("retired_in_rst", retired, 0);
        check("reg_wr_in_rst", reg_wr_en, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        exp_ret = 0; exp_o = '0; exp_o.ready = 1'b1; chk_sel = 1'b0; chk_en = 1'b1;
        step();
        run(7'b0000011, 1'b0, 2, 1'b0, lat); check("lat_lw_after_rst", lat, 6);
        check("retired_final", retired, 1);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the core datapath.
- Accepts one instruction word per handshake, decodes the opcode, and drives the operand-select controls (operand_ASel, extend_Sel, operand_BSel) for the whole instruction.
- Also sequences memory access, register writeback and PC update.
- Sits between the fetch unit and the operand-select/ALU/regfile datapath; one instruction in flight at a time.

Parameters:
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- halt  input  1  when high, blocks acceptance of a new instruction.
- instr_valid  input  1  fetch has an instruction on instr.
- instr_ready  output  1  controller can accept an instruction.
- instr  input  32  instruction word; only bits [6:0] are used here.
- branch_taken  input  1  branch comparator result from the datapath, valid in EXEC.
- mem_ack  input  1  data memory completes the current request.
- operand_ASel  output  2  00 rs1, 01 pc+4, 10 pc, 11 zero.
- extend_Sel  output  2  00 I-imm, 01 U-imm, 10 S-imm.
- operand_BSel  output  1  0 rs2, 1 immediate selected by extend_Sel.
- mem_req  output  1  data memory request.
- mem_we  output  1  1 store, 0 load; valid while mem_req.
- reg_wr_en  output  1  regfile write strobe.
- wb_sel  output  1  0 ALU result, 1 load data.
- pc_en  output  1  PC update strobe, one cycle per instruction.
- next_pc_sel  output  2  00 pc+4, 01 branch target, 10 jal target, 11 jalr target.
- illegal_instr  output  1  one-cycle pulse on an unknown opcode.
- retired  output  RET_W  count of completed instructions.

Behaviour:
- Reset: async on rst_n=0. State goes to FETCH; all outputs are 0 except instr_ready, which is 1 when halt=0. retired=0. Reset mid-instruction abandons it with no write and no PC update.
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - instr_ready = !halt.
  - On instr_valid && instr_ready: latch instr[6:0] and go to DECODE.
  - If halt is high, or valid is low, stay in FETCH.
- DECODE: register the select outputs from the latched opcode. They hold unchanged through the last state of the instruction.
  - R 0110011: A=00, B=0.
  - I-ALU 0010011: A=00, B=1, ext=00.
  - LOAD 0000011: A=00, B=1, ext=00.
  - STORE 0100011: A=00, B=1, ext=10.
  - BRANCH 1100011: A=00, B=0.
  - JAL 1101111: A=01, B=0.
  - JALR 1100111: A=01, B=0.
  - LUI 0110111: A=11, B=1, ext=01.
  - AUIPC 0010111: A=10, B=1, ext=01.
  - Any other opcode: pulse illegal_instr, pc_en=1 with next_pc_sel=00, go to FETCH. No retire increment.
  - Fields not listed above are 00/0.
  - Legal opcodes go to EXEC.
- EXEC:
  - BRANCH: pc_en=1, next_pc_sel = branch_taken ? 01 : 00, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - mem_req=1, mem_we = (STORE); held until mem_ack. mem_ack in the same cycle as the first mem_req is legal, giving a single MEM cycle.
  - On ack, LOAD goes to WB.
  - On ack, STORE asserts pc_en with next_pc_sel=00 in that same cycle and goes to FETCH.
  - mem_ack outside MEM is ignored.
- WB:
  - reg_wr_en=1, wb_sel = (LOAD), pc_en=1.
  - next_pc_sel: JAL 10, JALR 11, else 00.
  - Go to FETCH.
- Strobes: pc_en, reg_wr_en, mem_req and illegal_instr are Moore outputs of the current state (combinational from state plus latched opcode and, where stated, branch_taken/mem_ack).
- retired: increments by 1 in the cycle pc_en=1 for legal instructions and wraps from all-ones to 0.
- Latency from accept to back in FETCH:
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - LOAD: 4 cycles + MEM wait.
  - STORE: 3 cycles + MEM wait.
- halt: has no effect outside FETCH; an instruction in flight always completes.

Test Plan:
- Reset with instr_valid=1, then release rst_n: all outputs 0, retired=0. instr_ready=1 the cycle after release. First accept happens on the first clock edge with rst_n=1.
- ADDI (0010011) accepted: from DECODE, operand_ASel=00, operand_BSel=1, extend_Sel=00. reg_wr_en=pc_en=1 exactly in the 4th cycle. retired=1.
- LW with mem_ack delayed 3 cycles: mem_req high 3 cycles, mem_we=0. Then WB with wb_sel=1 and reg_wr_en=1. Total 7 cycles accept→FETCH.
- SW with immediate mem_ack: extend_Sel=10, mem_we=1, one MEM cycle with pc_en=1, no reg_wr_en.
- BEQ with branch_taken=1, then again with 0: next_pc_sel=01, then 00, each with pc_en in EXEC (3rd cycle). JAL: operand_ASel=01, next_pc_sel=10 in WB.
- Opcode 1111111: illegal_instr one-cycle pulse in DECODE, no reg write, retired unchanged.
- RET_W=2 with 5 retires: retired reads 1.
- halt=1 in FETCH: instr_ready=0 and no accept.
- rst_n low during MEM: mem_req drops immediately and state returns to FETCH.
